// File: rtl/alu_regfile_seq_pkg.sv
// Shared definitions for the operand/writeback stage around the 4-bit ALU:
// opcode constants, default widths and the sequencer state encoding.
package alu_regfile_seq_pkg;

  localparam int DATA_W_DEF   = 4;
  localparam int NUM_REGS_DEF = 8;
  localparam int ADDR_W_DEF   = 3;

  typedef logic [1:0] op_t;

  localparam op_t OP_ADD  = 2'b00;
  localparam op_t OP_SUB  = 2'b01;
  localparam op_t OP_NAND = 2'b10;
  localparam op_t OP_XOR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WB   = 2'b10
  } state_t;

endpackage

// File: rtl/alu_regfile_seq_if.sv
// Instruction issue channel: valid/ready handshake plus the register-to-register
// instruction fields, which the upstream holds stable until accepted.
interface alu_regfile_seq_if
  import alu_regfile_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              instr_valid;
  logic              instr_ready;
  op_t               instr_op;
  logic [ADDR_W-1:0] instr_rd;
  logic [ADDR_W-1:0] instr_rs;
  logic [ADDR_W-1:0] instr_rt;

  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs, instr_rt,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs, instr_rt,
    output instr_ready
  );

endinterface

// File: rtl/alu_regfile_seq_regfile_8x4.sv
// Register file with one synchronous write port and NUM_RD combinational read
// ports; entry 0 is never written and every read of index 0 returns zero.
module regfile_8x4
  import alu_regfile_seq_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we,
  input  logic [ADDR_W-1:0]              waddr,
  input  logic [DATA_W-1:0]              wdata,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  raddr,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rdata
);

  logic [DATA_W-1:0] mem_reg [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem_reg[waddr] <= wdata;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      assign rdata[gi] = (raddr[gi] == '0) ? '0 : mem_reg[raddr[gi]];
    end
  endgenerate

endmodule

// File: rtl/alu_regfile_seq.sv
// Operand/writeback sequencer for an external combinational ALU: reads operands
// at accept, captures the ALU result one cycle later, writes it back the next.
module alu_regfile_seq
  import alu_regfile_seq_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  alu_regfile_seq_if.slave   instr_bus,
  output logic [DATA_W-1:0]  alu_in1,
  output logic [DATA_W-1:0]  alu_in2,
  output op_t                alu_opcode,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic               alu_error,
  output logic               done,
  output logic [DATA_W-1:0]  done_result,
  output logic               ovfl_sticky,
  input  logic               clr_ovfl,
  input  logic               dbg_we,
  input  logic [ADDR_W-1:0]  dbg_addr,
  input  logic [DATA_W-1:0]  dbg_wdata,
  output logic [DATA_W-1:0]  dbg_rdata
);

  localparam int RD_RS  = 0;
  localparam int RD_RT  = 1;
  localparam int RD_DBG = 2;

  state_t            state_reg;
  logic [ADDR_W-1:0] rd_reg;
  logic [DATA_W-1:0] in1_reg;
  logic [DATA_W-1:0] in2_reg;
  op_t               opcode_reg;
  logic [DATA_W-1:0] res_reg;
  logic              err_reg;
  logic              done_reg;
  logic              ovfl_reg;

  logic                          accept;
  logic                          rf_we;
  logic [ADDR_W-1:0]             rf_waddr;
  logic [DATA_W-1:0]             rf_wdata;
  logic [2:0][ADDR_W-1:0]        rf_raddr;
  logic [2:0][DATA_W-1:0]        rf_rdata;

  assign instr_bus.instr_ready = (state_reg == ST_IDLE);
  assign accept = instr_bus.instr_valid && (state_reg == ST_IDLE);

  assign rf_raddr[RD_RS]  = instr_bus.instr_rs;
  assign rf_raddr[RD_RT]  = instr_bus.instr_rt;
  assign rf_raddr[RD_DBG] = dbg_addr;

  // Writeback owns the write port in WB; debug writes only get it in an idle
  // cycle with no accept, so the two sources never collide.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = dbg_addr;
    rf_wdata = dbg_wdata;
    if (state_reg == ST_WB) begin
      rf_we    = 1'b1;
      rf_waddr = rd_reg;
      rf_wdata = res_reg;
    end else if ((state_reg == ST_IDLE) && !accept) begin
      rf_we = dbg_we;
    end
  end

  regfile_8x4 #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (3)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .raddr (rf_raddr),
    .rdata (rf_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      rd_reg     <= '0;
      in1_reg    <= '0;
      in2_reg    <= '0;
      opcode_reg <= OP_ADD;
      res_reg    <= '0;
      err_reg    <= 1'b0;
      done_reg   <= 1'b0;
      ovfl_reg   <= 1'b0;
    end else begin
      // A set from a committing overflow outranks a simultaneous clear.
      ovfl_reg <= (ovfl_reg & ~clr_ovfl) | ((state_reg == ST_WB) & err_reg);
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            rd_reg     <= instr_bus.instr_rd;
            in1_reg    <= rf_rdata[RD_RS];
            in2_reg    <= rf_rdata[RD_RT];
            opcode_reg <= instr_bus.instr_op;
            state_reg  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_reg   <= alu_out;
          err_reg   <= alu_error;
          done_reg  <= 1'b1;
          state_reg <= ST_WB;
        end
        ST_WB: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_in1     = in1_reg;
  assign alu_in2     = in2_reg;
  assign alu_opcode  = opcode_reg;
  assign done        = done_reg;
  assign done_result = res_reg;
  assign ovfl_sticky = ovfl_reg;
  assign dbg_rdata   = rf_rdata[RD_DBG];

endmodule

// File: tb/tb_alu_regfile_seq.sv
// Bench for alu_regfile_seq: models the external ALU, tracks a cycle-level
// reference of the register file and flags, and compares every cycle.
module tb_alu_regfile_seq;
  import alu_regfile_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] alu_in1, alu_in2, alu_out;
  op_t        alu_opcode;
  logic       alu_error;
  logic       done;
  logic [3:0] done_result;
  logic       ovfl_sticky;
  logic       clr_ovfl;
  logic       dbg_we;
  logic [2:0] dbg_addr;
  logic [3:0] dbg_wdata;
  logic [3:0] dbg_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  alu_regfile_seq_if #(.ADDR_W(3)) ifc ();

  always #5 clk = ~clk;

  alu_regfile_seq dut (
    .clk         (clk),
    .rst         (rst),
    .instr_bus   (ifc),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_opcode  (alu_opcode),
    .alu_out     (alu_out),
    .alu_error   (alu_error),
    .done        (done),
    .done_result (done_result),
    .ovfl_sticky (ovfl_sticky),
    .clr_ovfl    (clr_ovfl),
    .dbg_we      (dbg_we),
    .dbg_addr    (dbg_addr),
    .dbg_wdata   (dbg_wdata),
    .dbg_rdata   (dbg_rdata)
  );

  // 4-bit ALU: two's-complement overflow for ADD/SUB, no error for logic ops.
  function automatic void alu_fn(input op_t op, input logic [3:0] a, input logic [3:0] b,
                                 output logic [3:0] r, output logic e);
    case (op)
      OP_ADD:  begin r = a + b;    e = (a[3] == b[3]) && (r[3] != a[3]); end
      OP_SUB:  begin r = a - b;    e = (a[3] != b[3]) && (r[3] != a[3]); end
      OP_NAND: begin r = ~(a & b); e = 1'b0; end
      default: begin r = a ^ b;    e = 1'b0; end
    endcase
  endfunction

  always_comb begin
    alu_fn(alu_opcode, alu_in1, alu_in2, alu_out, alu_error);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: register contents, flags, and how many cycles into an
  // instruction we are (0 = free, 1 = ALU evaluating, 2 = result on done).
  logic [3:0] m_r [8];
  int         phase = 0;
  logic [3:0] m_a, m_b, m_res, m_held;
  op_t        m_op;
  logic [2:0] m_rd;
  logic       m_err, m_sticky;
  bit         acc_flag = 0;
  bit         cmp_en = 0;

  initial begin
    logic nxt_sticky;
    forever begin
      @(posedge clk);
      cyc++;
      acc_flag = 0;
      if (rst) begin
        for (int i = 0; i < 8; i++) m_r[i] = 4'd0;
        phase = 0; m_a = 0; m_b = 0; m_op = OP_ADD; m_res = 0; m_held = 0;
        m_err = 0; m_sticky = 0; m_rd = 0;
      end else begin
        nxt_sticky = (m_sticky && !clr_ovfl) || (phase == 2 && m_err);
        if (phase == 0) begin
          if (ifc.instr_valid) begin
            m_a  = m_r[ifc.instr_rs];
            m_b  = m_r[ifc.instr_rt];
            m_op = ifc.instr_op;
            m_rd = ifc.instr_rd;
            alu_fn(m_op, m_a, m_b, m_res, m_err);
            phase = 1;
            acc_flag = 1;
          end else if (dbg_we && dbg_addr != 3'd0) begin
            m_r[dbg_addr] = dbg_wdata;
          end
        end else if (phase == 1) begin
          m_held = m_res;
          phase = 2;
        end else begin
          if (m_rd != 3'd0) m_r[m_rd] = m_res;
          phase = 0;
        end
        m_sticky = nxt_sticky;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cmp_en) begin
        chk("ready", 32'(ifc.instr_ready), 32'(phase == 0));
        chk("done", 32'(done), 32'(phase == 2));
        chk("done_result", 32'(done_result), 32'(m_held));
        chk("ovfl_sticky", 32'(ovfl_sticky), 32'(m_sticky));
        chk("dbg_rdata", 32'(dbg_rdata), 32'(m_r[dbg_addr]));
        if (phase == 1) begin
          chk("alu_in1", 32'(alu_in1), 32'(m_a));
          chk("alu_in2", 32'(alu_in2), 32'(m_b));
          chk("alu_opcode", 32'(alu_opcode), 32'(m_op));
        end
      end
    end
  end

  task automatic issue(input op_t op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt, input bit keep, output int acc);
    acc = -1;
    @(negedge clk);
    dbg_we = 1'b0;
    ifc.instr_op = op; ifc.instr_rd = rd; ifc.instr_rs = rs; ifc.instr_rt = rt;
    ifc.instr_valid = 1'b1;
    for (int n = 0; n < 8; n++) begin
      if (ifc.instr_ready) begin
        acc = cyc;
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
    #1;
    if (!keep) ifc.instr_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic [3:0] exp, input int acc, input bit do_clr);
    bit seen = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({name, "_latency"}, 32'(cyc - acc), 32'd2);
      chk({name, "_result"}, 32'(done_result), 32'(exp));
      if (do_clr) begin
        clr_ovfl = 1'b1;
        @(negedge clk);
        clr_ovfl = 1'b0;
      end
    end
  endtask

  task automatic dbg_wr(input logic [2:0] a, input logic [3:0] d);
    @(negedge clk);
    dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    @(negedge clk);
    dbg_we = 1'b0;
  endtask

  task automatic dbg_chk(input string name, input logic [2:0] a, input logic [3:0] exp);
    @(negedge clk);
    dbg_addr = a;
    #1;
    chk(name, 32'(dbg_rdata), 32'(exp));
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    clr_ovfl = 1'b1;
    @(negedge clk);
    clr_ovfl = 1'b0;
  endtask

  initial begin
    int a1, a2;
    rst = 1'b1; clr_ovfl = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    ifc.instr_valid = 0; ifc.instr_op = OP_ADD; ifc.instr_rd = 0; ifc.instr_rs = 0; ifc.instr_rt = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(ifc.instr_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_result", 32'(done_result), 32'd0);
    chk("rst_sticky", 32'(ovfl_sticky), 32'd0);
    chk("rst_alu_in1", 32'(alu_in1), 32'd0);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    rst = 1'b0;
    cmp_en = 1;

    // ADD 3+4
    dbg_wr(1, 4'd3); dbg_wr(2, 4'd4);
    issue(OP_ADD, 3, 1, 2, 0, a1);
    chk("t1_ready_busy", 32'(ifc.instr_ready), 32'd0);
    wait_done("t1", 4'd7, a1, 0);
    dbg_chk("t1_r3", 3, 4'd7);
    chk("t1_sticky", 32'(ovfl_sticky), 32'd0);

    // ADD overflow, clear, then SUB overflow with clear in its WB cycle
    dbg_wr(1, 4'd7); dbg_wr(2, 4'd1);
    issue(OP_ADD, 4, 1, 2, 0, a1);
    wait_done("t2_add", 4'b1000, a1, 0);
    dbg_chk("t2_r4", 4, 4'b1000);
    chk("t2_sticky_set", 32'(ovfl_sticky), 32'd1);
    clr_pulse();
    #1;
    chk("t2_sticky_clr", 32'(ovfl_sticky), 32'd0);
    dbg_wr(1, 4'b1000);
    issue(OP_SUB, 5, 1, 2, 0, a1);
    wait_done("t2_sub", 4'd7, a1, 1);
    #1;
    chk("t2_set_wins", 32'(ovfl_sticky), 32'd1);
    dbg_chk("t2_r5", 5, 4'd7);
    clr_pulse();

    // logic ops leave the sticky flag alone
    dbg_wr(1, 4'b1100); dbg_wr(2, 4'b1010);
    issue(OP_NAND, 6, 1, 2, 0, a1);
    wait_done("t3_nand", 4'b0111, a1, 0);
    issue(OP_XOR, 7, 1, 2, 0, a1);
    wait_done("t3_xor", 4'b0110, a1, 0);
    dbg_chk("t3_r6", 6, 4'b0111);
    dbg_chk("t3_r7", 7, 4'b0110);
    chk("t3_sticky", 32'(ovfl_sticky), 32'd0);

    // R0 is never written
    dbg_wr(1, 4'd3); dbg_wr(2, 4'd4);
    issue(OP_ADD, 0, 1, 2, 0, a1);
    wait_done("t4", 4'd7, a1, 0);
    dbg_chk("t4_r0_wb", 0, 4'd0);
    dbg_wr(0, 4'hF);
    dbg_chk("t4_r0_dbg", 0, 4'd0);

    // back-to-back with RAW through R3; debug write during EXEC dropped
    issue(OP_ADD, 3, 1, 2, 1, a1);
    @(negedge clk);
    dbg_we = 1'b1; dbg_addr = 6; dbg_wdata = 4'd9;
    issue(OP_ADD, 5, 3, 1, 0, a2);
    chk("t5_spacing", 32'(a2 - a1), 32'd3);
    wait_done("t5", 4'd10, a2, 0);
    dbg_chk("t5_r5", 5, 4'd10);
    dbg_chk("t5_r6_kept", 6, 4'b0111);
    chk("t5_sticky", 32'(ovfl_sticky), 32'd1);

    // reset while in EXEC
    issue(OP_ADD, 3, 1, 2, 0, a1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_ready", 32'(ifc.instr_ready), 32'd1);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_sticky", 32'(ovfl_sticky), 32'd0);
    for (int r = 0; r < 8; r++) dbg_chk("t6_reg_zero", 3'(r), 4'd0);

    // randomized traffic
    repeat (400) begin
      @(negedge clk);
      rst = ($urandom_range(0, 79) == 0);
      if (!ifc.instr_valid || acc_flag) begin
        ifc.instr_valid = ($urandom_range(0, 2) != 0);
        ifc.instr_op = 2'($urandom);
        ifc.instr_rd = 3'($urandom);
        ifc.instr_rs = 3'($urandom);
        ifc.instr_rt = 3'($urandom);
      end
      dbg_we    = ($urandom_range(0, 3) == 0);
      dbg_addr  = 3'($urandom);
      dbg_wdata = 4'($urandom);
      clr_ovfl  = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    rst = 0; ifc.instr_valid = 0; dbg_we = 0; clr_ovfl = 0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
